// File: rtl/matrix_stream_host.sv
// Host-side streaming driver for the matrix multiplier: buffers operand rows,
// streams A then B rows to the core, then collects result rows into a readable buffer.
module matrix_stream_host #(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int MATRIX_WIDTH = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ld_valid,
  input  logic [$clog2(2*MATRIX_WIDTH)-1:0] ld_addr,
  input  logic [NUM_ELEMENTS*WIDTH-1:0]     ld_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              err_timeout,
  input  logic [$clog2(MATRIX_WIDTH)-1:0]   res_addr,
  output logic [NUM_ELEMENTS*WIDTH-1:0]     res_data,
  output logic [NUM_ELEMENTS*WIDTH-1:0]     mm_rdata,
  output logic                              mm_read_en,
  output logic                              mm_write_en,
  input  logic [NUM_ELEMENTS*WIDTH-1:0]     mm_res,
  input  logic                              mm_write_ready
);
  localparam int ROW_W = NUM_ELEMENTS * WIDTH;
  localparam int OPS   = 2 * MATRIX_WIDTH;
  localparam int RA_W  = $clog2(MATRIX_WIDTH);
  localparam int LA_W  = $clog2(OPS);
  localparam int CNT_W = $clog2(OPS + 1);
  localparam int WT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] SEND_END  = CNT_W'(OPS);
  localparam logic [RA_W-1:0]  RES_LAST  = RA_W'(MATRIX_WIDTH - 1);
  localparam logic [WT_W-1:0]  WAIT_LAST = WT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] op_buf  [OPS];
  logic [ROW_W-1:0] res_buf [MATRIX_WIDTH];
  logic [CNT_W-1:0] row_cnt;
  logic [RA_W-1:0]  res_cnt;
  logic [WT_W-1:0]  wait_cnt;
  logic             ld_we;
  logic [ROW_W-1:0] first_row;

  assign ld_we = ld_valid && (state == S_IDLE) && (int'(ld_addr) < OPS);

  // A row-0 load on the start edge must reach the stream, so bypass the buffer.
  assign first_row = (ld_we && (ld_addr == '0)) ? ld_data : op_buf[0];

  assign res_data = (int'(res_addr) < MATRIX_WIDTH) ? res_buf[res_addr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      mm_read_en  <= 1'b0;
      mm_write_en <= 1'b0;
      mm_rdata    <= '0;
      row_cnt     <= '0;
      res_cnt     <= '0;
      wait_cnt    <= '0;
      for (int i = 0; i < OPS; i++) op_buf[i] <= '0;
      for (int i = 0; i < MATRIX_WIDTH; i++) res_buf[i] <= '0;
    end else begin
      done <= 1'b0;
      if (ld_we) op_buf[ld_addr] <= ld_data;
      case (state)
        // DONE already reports not-busy, so a start there is taken back-to-back.
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            state       <= S_SEND;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            mm_read_en  <= 1'b1;
            mm_rdata    <= first_row;
            row_cnt     <= CNT_W'(1);
          end
        end
        S_SEND: begin
          if (row_cnt == SEND_END) begin
            mm_read_en  <= 1'b0;
            mm_write_en <= 1'b1;
            wait_cnt    <= '0;
            state       <= S_WAIT;
          end else begin
            mm_rdata <= op_buf[row_cnt[LA_W-1:0]];
            row_cnt  <= row_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mm_write_ready) begin
            res_buf[0] <= mm_res;
            res_cnt    <= RA_W'(1);
            state      <= S_COLLECT;
          end else if (wait_cnt == WAIT_LAST) begin
            err_timeout <= 1'b1;
            mm_write_en <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WT_W'(1);
          end
        end
        S_COLLECT: begin
          if (mm_write_ready) begin
            res_buf[res_cnt] <= mm_res;
            res_cnt          <= res_cnt + RA_W'(1);
            if (res_cnt == RES_LAST) begin
              done        <= 1'b1;
              busy        <= 1'b0;
              mm_write_en <= 1'b0;
              state       <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_stream_host.sv
// Scoreboard bench for matrix_stream_host: expected stream rows and result matrices
// are queued by the stimulus and popped by an independent monitor.
module tb_matrix_stream_host;
  localparam int W   = 8;
  localparam int NE  = 4;
  localparam int MW  = 4;
  localparam int TMO = 64;
  localparam int RW  = NE * W;

  logic          clk = 1'b0;
  logic          reset, ld_valid, start, mm_write_ready;
  logic [2:0]    ld_addr;
  logic [RW-1:0] ld_data, mm_res;
  logic [1:0]    res_addr;
  logic          busy, done, err_timeout, mm_read_en, mm_write_en;
  logic [RW-1:0] res_data, mm_rdata;

  int checks = 0, errors = 0, done_cnt = 0, exp_done = 0, req_cnt = 0, ack_cnt = 0;
  logic [RW-1:0]    model_op [2*MW];
  logic [RW-1:0]    rd_q [$];
  logic [MW*RW-1:0] res_q [$];
  logic [MW*RW-1:0] last_res;

  matrix_stream_host #(.WIDTH(W), .NUM_ELEMENTS(NE), .MATRIX_WIDTH(MW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .err_timeout(err_timeout),
    .res_addr(res_addr), .res_data(res_data), .mm_rdata(mm_rdata),
    .mm_read_en(mm_read_en), .mm_write_en(mm_write_en), .mm_res(mm_res),
    .mm_write_ready(mm_write_ready)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_res(input logic [MW*RW-1:0] m, input string tag);
    for (int r = 0; r < MW; r++) begin
      res_addr = 2'(r);
      #2;
      chk(tag, res_data, m[r*RW +: RW]);
    end
    res_addr = 2'd0;
  endtask

  // Monitor: owns res_addr and consumes the expectation queues.
  initial begin
    logic [MW*RW-1:0] m;
    res_addr = 2'd0;
    last_res = '0;
    forever begin
      @(negedge clk);
      if (reset) last_res = '0;
      if (mm_read_en) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_unexpected: got row %0h, expected no row", mm_rdata);
        end else begin
          chk("stream_row", mm_rdata, rd_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done=1, expected 0");
        end else begin
          m = res_q.pop_front();
          compare_res(m, "result_row");
          last_res = m;
        end
      end else if (ack_cnt != req_cnt) begin
        compare_res(last_res, "result_persist");
        ack_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before 400000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic load_row(input logic [2:0] a, input logic [RW-1:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d; model_op[a] = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic kick(input bit with_ld, input logic [2:0] a, input logic [RW-1:0] d);
    start = 1'b1;
    if (with_ld) begin
      ld_valid = 1'b1; ld_addr = a; ld_data = d; model_op[a] = d;
    end
    for (int r = 0; r < 2*MW; r++) rd_q.push_back(model_op[r]);
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_by_start", err_timeout, 0);
  endtask

  task automatic stream_check(input bit poke);
    int cnt = 0;
    bit seen = 0, poked = 0;
    for (int i = 0; i < 30; i++) begin
      if (poked) begin start = 1'b0; ld_valid = 1'b0; end
      if (mm_write_en) begin seen = 1; break; end
      if (mm_read_en) cnt++;
      if (poke && cnt == 3 && !poked) begin
        poked = 1; start = 1'b1; ld_valid = 1'b1; ld_addr = 3'd2; ld_data = ~model_op[2];
      end
      @(negedge clk);
    end
    start = 1'b0; ld_valid = 1'b0;
    chk("wait_entered", seen, 1);
    chk("read_en_cycles", cnt, 2*MW);
    chk("read_en_low_in_wait", mm_read_en, 0);
    chk("rdata_held", mm_rdata, model_op[2*MW-1]);
  endtask

  task automatic respond(input bit directed);
    logic [MW*RW-1:0] m;
    int pat [6] = '{1, 0, 1, 1, 0, 1};
    int k = 0;
    for (int r = 0; r < MW; r++) m[r*RW +: RW] = directed ? RW'(32'hA0 + r) : $urandom;
    res_q.push_back(m);
    exp_done++;
    if (directed) begin
      for (int i = 0; i < 6; i++) begin
        mm_write_ready = (pat[i] != 0);
        if (pat[i] != 0) begin mm_res = m[k*RW +: RW]; k++; end
        else mm_res = $urandom;
        @(negedge clk);
      end
    end else begin
      for (int r = 0; r < MW; r++) begin
        repeat ($urandom_range(0, 2)) begin
          mm_write_ready = 1'b0; mm_res = $urandom;
          @(negedge clk);
        end
        mm_write_ready = 1'b1; mm_res = m[r*RW +: RW];
        @(negedge clk);
      end
    end
    mm_write_ready = 1'b0;
  endtask

  task automatic wait_done(input bit b2b);
    bit seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("done_seen", seen, 1);
    chk("busy_low_with_done", busy, 0);
    chk("write_en_low_with_done", mm_write_en, 0);
    if (b2b) kick(0, 3'd0, '0);
    else begin
      @(negedge clk);
      chk("done_single_cycle", done, 0);
    end
  endtask

  task automatic res_recheck();
    bit ok = 0;
    req_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack_cnt == req_cnt) begin ok = 1; break; end
    end
    chk("result_recheck_done", ok, 1);
  endtask

  initial begin
    int cnt;
    bit early;
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    mm_res = '0; mm_write_ready = 1'b0;
    for (int r = 0; r < 2*MW; r++) model_op[r] = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err_timeout, 0);
    chk("reset_read_en", mm_read_en, 0);
    chk("reset_write_en", mm_write_en, 0);
    chk("reset_rdata", mm_rdata, 0);
    chk("reset_res_data", res_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed load, stream order and stalled collection.
    for (int r = 0; r < MW; r++) begin
      load_row(3'(r), {NE{8'(r + 1)}});
      load_row(3'(MW + r), {NE{8'(8'h11 + r)}});
    end
    kick(0, 3'd0, '0);
    stream_check(0);
    respond(1);
    wait_done(0);

    // Result handshakes outside a transaction must not touch the results.
    for (int i = 0; i < 3; i++) begin
      mm_write_ready = 1'b1; mm_res = $urandom;
      @(negedge clk);
    end
    mm_write_ready = 1'b0;
    chk("idle_ready_no_busy", busy, 0);
    res_recheck();

    // start and ld_valid pulsed mid-stream are dropped.
    kick(0, 3'd0, '0);
    stream_check(1);
    respond(0);
    wait_done(0);
    repeat (4) @(negedge clk);
    chk("no_queued_start", busy, 0);

    // Timeout with ready never asserted; the stream also proves the buffer kept its rows.
    kick(0, 3'd0, '0);
    stream_check(0);
    early = 0;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      if (i < TMO && (err_timeout || !mm_write_en)) early = 1;
    end
    chk("timeout_not_early", early, 0);
    chk("timeout_err", err_timeout, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_write_en", mm_write_en, 0);
    repeat (3) @(negedge clk);
    chk("timeout_err_sticky", err_timeout, 1);
    kick(0, 3'd0, '0);
    stream_check(0);
    respond(0);
    wait_done(0);

    // Random loads, loads on the start edge, and one back-to-back pair.
    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < 3; j++) load_row(3'($urandom_range(0, 2*MW-1)), $urandom);
      kick(1, (t == 0) ? 3'd0 : 3'($urandom_range(0, 2*MW-1)), $urandom);
      stream_check(0);
      respond(0);
      wait_done(t == 1);
      if (t == 1) begin
        stream_check(0);
        respond(0);
        wait_done(0);
      end
    end

    // Asynchronous reset on the third streamed row.
    kick(0, 3'd0, '0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mm_read_en) cnt++;
      if (cnt == 3) break;
      @(negedge clk);
    end
    chk("reset_at_third_row", cnt, 3);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_read_en", mm_read_en, 0);
    chk("mid_reset_write_en", mm_write_en, 0);
    chk("mid_reset_rdata", mm_rdata, 0);
    chk("mid_reset_res_data", res_data, 0);
    rd_q.delete();
    for (int r = 0; r < 2*MW; r++) model_op[r] = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    res_recheck();
    kick(0, 3'd0, '0);
    stream_check(0);
    respond(0);
    wait_done(0);

    repeat (5) @(negedge clk);
    chk("stream_queue_drained", rd_q.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);
    chk("done_pulse_count", done_cnt, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
